mdu_unit: RTL and testbench
===========================

# mdu_unit

Multi-cycle multiply/divide unit for the P6 five-stage MIPS pipeline, sitting in the EX stage. It holds the architectural HI/LO registers, runs MULT/MULTU/DIV/DIVU over a fixed cycle count with a busy indication for the hazard unit, and executes MTHI/MTLO/MFHI/MFLO. Its `mdu_out` result feeds the EX/MEM pipeline register's MDU result field.

## Interface

- `MULT_CYCLES`, default 5: busy duration for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy duration for DIV/DIVU.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle launch of the operation in `mdu_op` (1–4 only).
- `mdu_op`  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9–15 treated as NONE.
- `rs_val`  in  32  operand A / dividend / MTHI-MTLO source (already forwarded).
- `rt_val`  in  32  operand B / divisor.
- `busy`  out  1  high while a multiply/divide is in flight.
- `hi_out`  out  32  architectural HI.
- `lo_out`  out  32  architectural LO.
- `mdu_out`  out  32  HI when `mdu_op`=7, LO when `mdu_op`=8, otherwise 0; combinational.

## Operation

- Registers: `hi`, `lo`, `hi_tmp`, `lo_tmp` (32 bits each), 4-bit down-counter `cnt`, and `busy`.
- Launch: on an edge with `start`=1, `busy`=0 and `mdu_op` in 1–4:
  - The full result is computed from `rs_val`/`rt_val` into `hi_tmp`/`lo_tmp`.
  - `cnt` loads MULT_CYCLES or DIV_CYCLES; `busy` is set.
- MULT: signed 32×32 to 64 bits. MULTU: unsigned. HI = bits [63:32], LO = bits [31:0].
- DIV: signed; quotient truncates toward zero and goes to LO; remainder takes the dividend's sign and goes to HI.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (two's-complement wrap).
- DIVU: unsigned quotient to LO, remainder to HI.
- Divide by zero (`rt_val`=0): the operation still runs DIV_CYCLES with `busy` high; HI/LO are left unchanged at completion.
- Countdown: while `busy`, `cnt` decrements each edge. On the edge where `cnt`=1, `hi`/`lo` take `hi_tmp`/`lo_tmp` (unless it was a divide by zero), `busy` clears and `cnt` becomes 0.
- MTHI/MTLO: when `mdu_op`=5/6 and `busy`=0, `hi`/`lo` take `rs_val` on the edge. `start` is not required.
- Ignored while busy: `start`, MTHI and MTLO are all ignored while `busy`=1. The hazard unit never issues them in that state; the block must still not corrupt state if they arrive.
- `start` with `mdu_op` outside 1–4 does nothing.

## Timing

- Reset: `hi`, `lo`, `hi_tmp`, `lo_tmp` = 0; `cnt` = 0; `busy` = 0. Therefore `hi_out`=`lo_out`=0, and `mdu_out`=0 unless `mdu_op` selects 7/8.
- Reset mid-operation aborts the operation: no HI/LO commit, `busy`=0 on the next cycle. Reset wins over a simultaneous `start`.
- Launch at edge T:
  - `busy`=1 during cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES).
  - New HI/LO are visible and `busy`=0 from cycle T+N+1.
- Back-to-back: a `start` in the first cycle with `busy`=0 (the cycle right after completion) launches normally.
- Old values hold: `hi_out`/`lo_out` keep their old values for the whole busy window.
- `mdu_out` tracks `mdu_op` combinationally in the same cycle. An MFHI in the same cycle as an MTHI returns the old HI.
- The stall rule lives outside this block (D-stage MDU instruction while `busy` or E-stage `start`). This block only guarantees the `busy` timing above.

## Test plan

- **Reset:** assert `reset` 2 cycles → `busy`=0, `hi_out`=`lo_out`=0, and `mdu_out`=0 with `mdu_op`=7.
- **MULT −3 × 7:** `start` with op 1, rs=0xFFFFFFFD, rt=7.
  - `busy` high exactly 5 cycles; HI/LO unchanged during the window.
  - Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - MULTU with the same operands then gives HI=0x00000006, LO=0xFFFFFFEB.
- **DIV −7 / 2:** LO=0xFFFFFFFD, HI=0xFFFFFFFF after exactly 10 busy cycles.
  - DIVU 7/2: LO=3, HI=1.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- **Divide by zero:** MTHI 0x1234, then MTLO 0x5678, then DIV 5/0 → `busy` 10 cycles; HI=0x1234 and LO=0x5678 are preserved.
- **Ignored while busy:** during a MULT busy window, drive MTLO 0xAAAA and a second `start` → both are ignored.
  - The final LO is the product; `busy` drops on the original schedule.
- **Reset mid-operation:** start DIV 100/3 and assert `reset` at busy cycle 4 → next cycle `busy`=0, HI=LO=0, and no commit occurs later.

Source files
------------

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit for the EX stage: owns HI/LO, computes results at launch
// and commits them after a fixed busy window so the hazard unit sees deterministic timing.
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic [31:0] mdu_out
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
   logic        div0_q, div0_d;

   logic        launch, done, is_div;
   logic [63:0] mul_a, mul_b, prod;
   logic [31:0] abs_a, abs_b, uq, ur, quot, rem;
   logic        a_neg, b_neg, signed_div;

   assign launch = start && (state_q == S_IDLE) && (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);
   assign done   = (state_q == S_BUSY) && (cnt_q == 4'd1);
   assign is_div = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);

   // Low 64 bits of a 64x64 product equal the 32x32 product once operands are extended correctly.
   always_comb begin
      if (mdu_op == OP_MULT) begin
         mul_a = {{32{rs_val[31]}}, rs_val};
         mul_b = {{32{rt_val[31]}}, rt_val};
      end else begin
         mul_a = {32'd0, rs_val};
         mul_b = {32'd0, rt_val};
      end
      prod = mul_a * mul_b;
   end

   // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
   always_comb begin
      signed_div = (mdu_op == OP_DIV);
      a_neg      = signed_div && rs_val[31];
      b_neg      = signed_div && rt_val[31];
      abs_a      = a_neg ? (32'd0 - rs_val) : rs_val;
      abs_b      = b_neg ? (32'd0 - rt_val) : rt_val;
      uq         = 32'd0;
      ur         = 32'd0;
      if (abs_b != 32'd0) begin
         uq = abs_a / abs_b;
         ur = abs_a % abs_b;
      end
      quot = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
      rem  = a_neg ? (32'd0 - ur) : ur;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (launch) state_d = S_BUSY;
         S_BUSY:  if (done)   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state_q == S_BUSY);
      case (mdu_op)
         OP_MFHI: mdu_out = hi_q;
         OP_MFLO: mdu_out = lo_q;
         default: mdu_out = 32'd0;
      endcase
   end

   assign hi_out = hi_q;
   assign lo_out = lo_q;

   // Datapath next-state: launch, countdown/commit, and idle-only MTHI/MTLO.
   always_comb begin
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      hi_tmp_d = hi_tmp_q;
      lo_tmp_d = lo_tmp_q;
      div0_d   = div0_q;
      if (state_q == S_BUSY) begin
         if (done) begin
            cnt_d = 4'd0;
            if (!div0_q) begin
               hi_d = hi_tmp_q;
               lo_d = lo_tmp_q;
            end
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end else if (launch) begin
         div0_d = is_div && (rt_val == 32'd0);
         if (is_div) begin
            cnt_d    = 4'(DIV_CYCLES);
            hi_tmp_d = rem;
            lo_tmp_d = quot;
         end else begin
            cnt_d    = 4'(MULT_CYCLES);
            hi_tmp_d = prod[63:32];
            lo_tmp_d = prod[31:0];
         end
      end else if (mdu_op == OP_MTHI) begin
         hi_d = rs_val;
      end else if (mdu_op == OP_MTLO) begin
         lo_d = rs_val;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= 4'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         hi_tmp_q <= 32'd0;
         lo_tmp_q <= 32'd0;
         div0_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         hi_tmp_q <= hi_tmp_d;
         lo_tmp_q <= lo_tmp_d;
         div0_q   <= div0_d;
      end
   end

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed operations, expected HI/LO and busy length queued at launch,
// a monitor pops and checks whenever busy falls.
module tb_mdu_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  mdu_op;
   logic [31:0] rs_val, rt_val;
   logic        busy;
   logic [31:0] hi_out, lo_out, mdu_out;

   int total = 0;
   int bad   = 0;

   logic [63:0] exp_q[$];
   int          cyc_q[$];
   logic [31:0] model_hi = 32'd0;
   logic [31:0] model_lo = 32'd0;

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
      .rs_val(rs_val), .rt_val(rt_val), .busy(busy),
      .hi_out(hi_out), .lo_out(lo_out), .mdu_out(mdu_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: samples just after each rising edge.
   logic busy_prev = 1'b0;
   int   busy_cnt  = 0;
   always @(posedge clk) begin
      logic        rst_s;
      logic [63:0] e;
      int          c;
      rst_s = reset;
      #1;
      if (rst_s) begin
         busy_cnt = 0;
      end else if (busy === 1'b1) begin
         busy_cnt++;
         chk("hold_hi", hi_out, model_hi);
         chk("hold_lo", lo_out, model_lo);
      end else if (busy_prev) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            chk("done_hi", hi_out, e[63:32]);
            chk("done_lo", lo_out, e[31:0]);
            chk("busy_cycles", 32'(busy_cnt), 32'(c));
         end
         busy_cnt = 0;
      end
      busy_prev = (busy === 1'b1);
   end

   // All driver tasks enter and leave on a falling edge.
   task automatic wait_idle();
      int i;
      for (i = 0; i < 60; i++) begin
         if (busy === 1'b0) break;
         @(negedge clk);
      end
      if (i == 60) chk("busy_timeout", 32'd1, 32'd0);
   endtask

   task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int cycles);
      start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
      exp_q.push_back({ehi, elo});
      cyc_q.push_back(cycles);
      @(negedge clk);
      start = 1'b0; mdu_op = 4'd0;
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int cycles);
      launch(op, a, b, ehi, elo, cycles);
      wait_idle();
      model_hi = ehi;
      model_lo = elo;
   endtask

   task automatic move_to(input logic [3:0] op, input logic [31:0] v);
      mdu_op = op; rs_val = v;
      @(negedge clk);
      mdu_op = 4'd0;
      if (op == 4'd5) model_hi = v;
      else            model_lo = v;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mdu_op = 4'd7; rs_val = 32'd0; rt_val = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi_out, 32'd0);
      chk("rst_lo", lo_out, 32'd0);
      chk("rst_mfhi", mdu_out, 32'd0);
      reset = 1'b0; mdu_op = 4'd0;
      @(negedge clk);

      run_op(4'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 5);
      mdu_op = 4'd7; #1 chk("mfhi_mult", mdu_out, 32'hFFFFFFFF);
      mdu_op = 4'd8; #1 chk("mflo_mult", mdu_out, 32'hFFFFFFEB);
      mdu_op = 4'd0; #1 chk("mdu_out_none", mdu_out, 32'd0);
      @(negedge clk);
      run_op(4'd2, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB, 5);
      run_op(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      run_op(4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10);
      // Back-to-back: launch in the first idle cycle after completion.
      run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);

      move_to(4'd5, 32'h1234);
      move_to(4'd6, 32'h5678);
      mdu_op = 4'd7; #1 chk("mfhi_mthi", mdu_out, 32'h1234);
      mdu_op = 4'd0;
      @(negedge clk);
      run_op(4'd3, 32'd5, 32'd0, 32'h1234, 32'h5678, 10);

      // Ignored while busy: MTLO and a second start inside the window.
      launch(4'd1, 32'd100, 32'd200, 32'd0, 32'h4E20, 5);
      mdu_op = 4'd6; rs_val = 32'hAAAA;
      @(negedge clk);
      start = 1'b1; mdu_op = 4'd1; rs_val = 32'd3; rt_val = 32'd3;
      @(negedge clk);
      start = 1'b0; mdu_op = 4'd0;
      wait_idle();
      model_hi = 32'd0; model_lo = 32'h4E20;
      @(negedge clk);
      chk("no_relaunch", {31'd0, busy}, 32'd0);

      // Reset mid-operation: no entry queued because no commit may happen.
      start = 1'b1; mdu_op = 4'd3; rs_val = 32'd100; rt_val = 32'd3;
      @(negedge clk);
      start = 1'b0; mdu_op = 4'd0;
      repeat (3) @(negedge clk);
      reset = 1'b1; model_hi = 32'd0; model_lo = 32'd0;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", hi_out, 32'd0);
      chk("abort_lo", lo_out, 32'd0);
      repeat (12) @(negedge clk);
      chk("abort_late_hi", hi_out, 32'd0);
      chk("abort_late_lo", lo_out, 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
